alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 188 ++++++++++++++++++
 tb/tb_alu_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Registered 16-op ALU with valid/ready handshake and a signed
//            shift-add multiplier. Optional flags: define ALU_SEQ_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [SEL_W-1:0]     sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y_a,
    output logic [WIDTH-1:0]     y_l
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic                 flag_z,
    output logic                 flag_n,
    output logic                 flag_v
`endif
);

    localparam int                c_W2       = 2 * WIDTH;
    localparam int                c_CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0]   c_CNT_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0]   c_CNT_ONE  = c_CW'(1);
    localparam logic [WIDTH-1:0]  c_ONE_W    = WIDTH'(1);
    localparam logic [c_W2-1:0]   c_ONE_2W   = c_W2'(1);
    localparam logic [SEL_W-1:0]  c_SEL_MUL  = SEL_W'(5);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [c_W2-1:0]  r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [c_W2-1:0]  r_acc;
    logic [c_CW-1:0]  r_cnt;
    logic             r_neg;

    logic [c_W2-1:0]  w_ax;
    logic [c_W2-1:0]  w_bx;
    logic [WIDTH-1:0] w_amag;
    logic [WIDTH-1:0] w_bmag;
    logic [31:0]      w_shamt;
    logic [WIDTH-1:0] w_rol;
    logic [c_W2-1:0]  w_alu_a;
    logic [WIDTH-1:0] w_alu_l;
    logic [c_W2-1:0]  w_acc_nxt;
    logic [c_W2-1:0]  w_prod;
    logic [c_W2-1:0]  w_res_a;
    logic [WIDTH-1:0] w_res_l;
    logic             w_load;

    assign w_ax     = {{WIDTH{a[WIDTH-1]}}, a};
    assign w_bx     = {{WIDTH{b[WIDTH-1]}}, b};
    // Magnitudes are unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1) without loss.
    assign w_amag   = a[WIDTH-1] ? (~a + c_ONE_W) : a;
    assign w_bmag   = b[WIDTH-1] ? (~b + c_ONE_W) : b;
    assign w_shamt  = 32'(b) % WIDTH;
    assign w_rol    = (a << w_shamt) | (a >> (WIDTH - w_shamt));

    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_prod    = r_neg ? (~w_acc_nxt + c_ONE_2W) : w_acc_nxt;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    always_comb begin
        w_alu_a = '0;
        w_alu_l = '0;
        case (sel)
            4'd0:  w_alu_a = w_ax + w_bx;
            4'd1:  w_alu_a = w_ax - w_bx;
            4'd2:  w_alu_a = w_ax + c_ONE_2W;
            4'd3:  w_alu_a = w_ax - c_ONE_2W;
            4'd4:  w_alu_a = ~w_ax + c_ONE_2W;
            4'd6:  w_alu_a = a[WIDTH-1] ? (~w_ax + c_ONE_2W) : w_ax;
            4'd7: begin
                if ($signed(a) < $signed(b)) w_alu_a = '1;
                else if (a != b)             w_alu_a = c_ONE_2W;
            end
            4'd8:  w_alu_l = a & b;
            4'd9:  w_alu_l = a | b;
            4'd10: w_alu_l = a ^ b;
            4'd11: w_alu_l = ~a;
            4'd12: w_alu_l = ~(a & b);
            4'd13: w_alu_l = ~(a | b);
            4'd14: w_alu_l = ~(a ^ b);
            4'd15: w_alu_l = w_rol;
            default: begin
                w_alu_a = '0;
                w_alu_l = '0;
            end
        endcase
    end

    // Result registers load either from the single-cycle ALU or the finished product.
    always_comb begin
        w_res_a = w_alu_a;
        w_res_l = w_alu_l;
        w_load  = 1'b0;
        if (r_state == S_MUL) begin
            w_res_a = w_prod;
            w_res_l = '0;
            w_load  = (r_cnt == c_CNT_LAST);
        end else if (r_state == S_IDLE) begin
            w_load  = in_valid && (sel != c_SEL_MUL);
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic           w_res_logic;
    logic [WIDTH:0] w_hi;
    logic           w_fz;
    logic           w_fn;
    logic           w_fv;

    assign w_res_logic = (r_state == S_MUL) ? 1'b0 : sel[3];
    assign w_hi        = w_res_a[c_W2-1:WIDTH-1];
    assign w_fz        = w_res_logic ? ~(|w_res_l) : ~(|w_res_a);
    assign w_fn        = w_res_logic ? w_res_l[WIDTH-1] : w_res_a[c_W2-1];
    assign w_fv        = ~w_res_logic & ~((&w_hi) | ~(|w_hi));
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = (sel == c_SEL_MUL) ? S_MUL : S_DONE;
            S_MUL:  if (r_cnt == c_CNT_LAST) w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            y_a      <= '0;
            y_l      <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            flag_v   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && in_valid && sel == c_SEL_MUL) begin
                r_mcand  <= {{WIDTH{1'b0}}, w_amag};
                r_mplier <= w_bmag;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_neg    <= a[WIDTH-1] ^ b[WIDTH-1];
            end else if (r_state == S_MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + c_CNT_ONE;
            end
            if (w_load) begin
                y_a    <= w_res_a;
                y_l    <= w_res_l;
`ifdef ALU_SEQ_FLAGS_EN
                flag_z <= w_fz;
                flag_n <= w_fn;
                flag_v <= w_fv;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Randomised and directed bench for alu_seq against an integer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [3:0]     sel = '0;
    logic           in_ready;
    logic           out_valid;
    logic [2*W-1:0] y_a;
    logic [W-1:0]   y_l;
`ifdef ALU_SEQ_FLAGS_EN
    logic           flag_z;
    logic           flag_n;
    logic           flag_v;
    logic           obs_z;
    logic           obs_n;
    logic           obs_v;
`endif

    int             tests = 0;
    int             fails = 0;
    logic [2*W-1:0] obs_a;
    logic [W-1:0]   obs_l;
    int             obs_lat;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .SEL_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .y_a(y_a), .y_l(y_l)
`ifdef ALU_SEQ_FLAGS_EN
        , .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
`endif
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    // Reference: plain integer arithmetic on the signed values of the operands.
    function automatic void model(input int av, input int bv, input int s,
                                  output int ya, output int yl);
        int sa, sb, sh;
        sa = (av >= 8) ? av - 16 : av;
        sb = (bv >= 8) ? bv - 16 : bv;
        sh = bv % W;
        ya = 0;
        yl = 0;
        case (s)
            0:  ya = sa + sb;
            1:  ya = sa - sb;
            2:  ya = sa + 1;
            3:  ya = sa - 1;
            4:  ya = -sa;
            5:  ya = sa * sb;
            6:  ya = (sa < 0) ? -sa : sa;
            7:  ya = (sa < sb) ? -1 : ((sa == sb) ? 0 : 1);
            8:  yl = av & bv;
            9:  yl = av | bv;
            10: yl = av ^ bv;
            11: yl = (~av) & 15;
            12: yl = (~(av & bv)) & 15;
            13: yl = (~(av | bv)) & 15;
            14: yl = (~(av ^ bv)) & 15;
            default: yl = ((av << sh) | (av >> (W - sh))) & 15;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, wait (bounded) for its result, then consume it.
    task automatic run_op(input int ta, input int tb, input int ts, input int hold);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        a = W'(ta);
        b = W'(tb);
        sel = 4'(ts);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        obs_lat = 1;
        while (!out_valid && obs_lat < 60) begin
            tick();
            obs_lat++;
        end
        obs_a = y_a;
        obs_l = y_l;
`ifdef ALU_SEQ_FLAGS_EN
        obs_z = flag_z;
        obs_n = flag_n;
        obs_v = flag_v;
`endif
        for (int i = 0; i < hold; i++) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (y_a !== 8'h00) begin fails++; $display("FAIL reset_y_a got=%h exp=00", y_a); end
        tests++; if (y_l !== 4'h0) begin fails++; $display("FAIL reset_y_l got=%h exp=0", y_l); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add_sub();
        run_op(1, 11, 0, 0);
        tests++; if (obs_lat !== 1) begin fails++; $display("FAIL add_latency got=%0d exp=1", obs_lat); end
        tests++; if (obs_a !== 8'hFC) begin fails++; $display("FAIL add_y_a got=%h exp=fc", obs_a); end
        tests++; if (obs_l !== 4'h0) begin fails++; $display("FAIL add_y_l got=%h exp=0", obs_l); end
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin fails++; $display("FAIL add_release got=%b%b exp=01", out_valid, in_ready); end
        run_op(1, 11, 1, 2);
        tests++; if (obs_a !== 8'h06) begin fails++; $display("FAIL sub_y_a got=%h exp=06", obs_a); end
    endtask

    task automatic test_sweep();
        int ea, el;
        int av[3] = '{1, 8, 8};
        int bv[3] = '{11, 7, 8};
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 16; s++) begin
                model(av[k], bv[k], s, ea, el);
                run_op(av[k], bv[k], s, 0);
                tests++; if (obs_a !== ea[7:0])
                    begin fails++; $display("FAIL sweep_y_a a=%0d b=%0d sel=%0d got=%h exp=%h", av[k], bv[k], s, obs_a, ea[7:0]); end
                tests++; if (obs_l !== el[3:0])
                    begin fails++; $display("FAIL sweep_y_l a=%0d b=%0d sel=%0d got=%h exp=%h", av[k], bv[k], s, obs_l, el[3:0]); end
                tests++; if (obs_lat !== ((s == 5) ? 5 : 1))
                    begin fails++; $display("FAIL sweep_latency sel=%0d got=%0d exp=%0d", s, obs_lat, (s == 5) ? 5 : 1); end
            end
        end
    endtask

    task automatic test_mul();
        int lat;
        bit ready_seen;
        bit extra;
        ready_seen = 1'b0;
        a = 4'h8; b = 4'h8; sel = 4'd5; in_valid = 1'b1;
        tick();
        a = 4'h3; b = 4'h3; sel = 4'd0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            if (in_ready) ready_seen = 1'b1;
            tick();
            lat++;
        end
        in_valid = 1'b0;
        tests++; if (ready_seen !== 1'b0) begin fails++; $display("FAIL mul_in_ready got=1 exp=0 during multiply"); end
        tests++; if (lat !== 5) begin fails++; $display("FAIL mul_latency got=%0d exp=5", lat); end
        tests++; if (y_a !== 8'd64) begin fails++; $display("FAIL mul_y_a got=%h exp=40", y_a); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin fails++; $display("FAIL mul_release got=%b%b exp=01", out_valid, in_ready); end
        extra = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) extra = 1'b1;
            tick();
        end
        tests++; if (extra !== 1'b0) begin fails++; $display("FAIL mul_ignored_input got=extra_result exp=none"); end
        tests++; if (y_a !== 8'd64) begin fails++; $display("FAIL mul_hold_value got=%h exp=40", y_a); end
    endtask

    task automatic test_back_to_back();
        a = 4'h7; b = 4'h7; sel = 4'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || y_a !== 8'd14)
                begin fails++; $display("FAIL backpressure cyc=%0d got=%b%b/%h exp=10/0e", i, out_valid, in_ready, y_a); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL backpressure_release got=%b exp=1", in_ready); end
        run_op(2, 3, 1, 0);
        tests++; if (obs_a !== 8'hFF || obs_lat !== 1)
            begin fails++; $display("FAIL after_backpressure got=%h/%0d exp=ff/1", obs_a, obs_lat); end
    endtask

    task automatic test_reset_mid_mul();
        bit stale;
        a = 4'h7; b = 4'h7; sel = 4'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || y_a !== 8'h00)
            begin fails++; $display("FAIL reset_mid_mul got=%b%b/%h exp=01/00", out_valid, in_ready, y_a); end
        rst = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid || y_a !== 8'h00) stale = 1'b1;
            tick();
        end
        tests++; if (stale !== 1'b0) begin fails++; $display("FAIL reset_mid_mul_stale got=result exp=none"); end
    endtask

    task automatic test_random();
        int ta, tb, ts, ea, el;
        for (int n = 0; n < 80; n++) begin
            ta = $urandom_range(0, 15);
            tb = $urandom_range(0, 15);
            ts = $urandom_range(0, 15);
            model(ta, tb, ts, ea, el);
            run_op(ta, tb, ts, $urandom_range(0, 3));
            tests++; if (obs_a !== ea[7:0] || obs_l !== el[3:0])
                begin fails++; $display("FAIL random a=%0d b=%0d sel=%0d got=%h/%h exp=%h/%h", ta, tb, ts, obs_a, obs_l, ea[7:0], el[3:0]); end
            tests++; if (obs_lat !== ((ts == 5) ? 5 : 1))
                begin fails++; $display("FAIL random_latency sel=%0d got=%0d exp=%0d", ts, obs_lat, (ts == 5) ? 5 : 1); end
            tests++; if (y_a !== ea[7:0] || out_valid !== 1'b0)
                begin fails++; $display("FAIL random_after_release got=%h/%b exp=%h/0", y_a, out_valid, ea[7:0]); end
`ifdef ALU_SEQ_FLAGS_EN
            begin
                bit ez, en, ev;
                ez = (ts < 8) ? (ea == 0) : (el == 0);
                en = (ts < 8) ? (ea < 0) : el[3];
                ev = (ts < 8) && (ea < -8 || ea > 7);
                tests++; if ({obs_z, obs_n, obs_v} !== {ez, en, ev})
                    begin fails++; $display("FAIL random_flags sel=%0d got=%b%b%b exp=%b%b%b", ts, obs_z, obs_n, obs_v, ez, en, ev); end
            end
`endif
        end
    endtask

`ifdef ALU_SEQ_FLAGS_EN
    task automatic test_flags();
        run_op(7, 1, 0, 0);
        tests++; if (obs_a !== 8'd8 || obs_v !== 1'b1 || obs_n !== 1'b0)
            begin fails++; $display("FAIL flags_add got=%h v=%b n=%b exp=08 v=1 n=0", obs_a, obs_v, obs_n); end
        run_op(3, 3, 1, 0);
        tests++; if (obs_z !== 1'b1) begin fails++; $display("FAIL flags_sub_z got=%b exp=1", obs_z); end
        run_op(0, 0, 11, 0);
        tests++; if (obs_l !== 4'hF || obs_n !== 1'b1 || obs_v !== 1'b0)
            begin fails++; $display("FAIL flags_not got=%h n=%b v=%b exp=f n=1 v=0", obs_l, obs_n, obs_v); end
    endtask
`endif

    initial begin
        test_reset();
        test_add_sub();
        test_sweep();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
`ifdef ALU_SEQ_FLAGS_EN
        test_flags();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
